// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and start/busy/done handshake.
// Optional macro MDU_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state;

  // Multiply: a_sh = shifted multiplicand, b_sh = remaining multiplier, acc = product.
  // Divide:   a_sh[WIDTH-1:0] = divisor, b_sh = dividend/quotient shifter, acc = remainder.
  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz_pend;

  logic               sign_a_in;
  logic               sign_b_in;
  logic               is_div_in;
  logic               dbz_in;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0]   b_mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   div_rem_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_iter;

  always_comb begin
    sign_a_in    = op[0] & opA[WIDTH-1];
    sign_b_in    = op[0] & opB[WIDTH-1];
    is_div_in    = op[1];
    dbz_in       = op[1] && (opB == '0);
    mag_a_in     = sign_a_in ? -opA : opA;
    mag_b_in     = sign_b_in ? -opB : opB;

    mul_acc_next = acc + (b_sh[0] ? a_sh : '0);
    b_mul_next   = b_sh >> 1;

    // Restoring step: a borrow out of the trial subtraction means keep the shifted remainder.
    div_shift    = {acc[WIDTH-1:0], b_sh[WIDTH-1]};
    div_trial    = {1'b0, div_shift} - {2'b00, a_sh[WIDTH-1:0]};
    div_rem_next = div_trial[WIDTH+1] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];

    prod_fix     = neg_q ? -acc : acc;
    quo_fix      = neg_q ? -b_sh : b_sh;
    rem_fix      = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

`ifdef MDU_EARLY_TERM_EN
    last_iter    = (cnt == '0) || (!is_div && (b_mul_next == '0));
`else
    last_iter    = (cnt == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      acc         <= '0;
      b_sh        <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= is_div_in ? {{WIDTH{1'b0}}, mag_b_in} : {{WIDTH{1'b0}}, mag_a_in};
            b_sh     <= is_div_in ? mag_a_in : mag_b_in;
            acc      <= dbz_in ? {{WIDTH{1'b0}}, opA} : '0;
            cnt      <= CNT_W'(WIDTH - 1);
            is_div   <= is_div_in;
            neg_q    <= sign_a_in ^ sign_b_in;
            neg_r    <= sign_a_in;
            dbz_pend <= dbz_in;
            busy     <= 1'b1;
            if (is_div_in && !dbz_in) begin
              div_by_zero <= 1'b0;
            end
            state    <= dbz_in ? FIX : RUN;
          end else begin
            if (hi_we) begin
              hi <= wr_data;
            end
            if (lo_we) begin
              lo <= wr_data;
            end
          end
        end

        RUN: begin
          if (is_div) begin
            acc  <= {{WIDTH{1'b0}}, div_rem_next};
            b_sh <= {b_sh[WIDTH-2:0], ~div_trial[WIDTH+1]};
          end else begin
            acc  <= mul_acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_mul_next;
          end
          if (last_iter) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        FIX: begin
          if (dbz_pend) begin
            lo          <= '1;
            hi          <= acc[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the CPU datapath and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Uses a start/busy/done handshake so the CPU stalls on reads of HI/LO while busy.
- Also supports direct HI/LO writes for MTHI/MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- opA  input  WIDTH  multiplicand, or dividend for division.
- opB  input  WIDTH  multiplier, or divisor for division.
- hi_we  input  1  write wr_data into HI (MTHI).
- lo_we  input  1  write wr_data into LO (MTLO).
- wr_data  input  WIDTH  data for HI/LO direct writes.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- div_by_zero  output  1  sticky flag, set by a division with opB==0.
- hi  output  WIDTH  HI register: product high half, or remainder.
- lo  output  WIDTH  LO register: product low half, or quotient.

Behaviour:
- Reset (async, rst_n low): state goes to IDLE immediately; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter cleared. Asserting reset mid-operation discards the operation, and HI/LO stay 0.
- States:
  - IDLE: on start=1, capture the magnitudes of opA/opB and the result sign flags, load counter=WIDTH-1, go to RUN, busy=1.
  - RUN: one iteration per clock. Multiply is radix-2 shift-add. Division is restoring shift-subtract, one quotient bit per clock. When counter==0, go to FIX; otherwise decrement the counter.
  - FIX: apply sign fixup, write HI/LO, pulse done=1, busy=0, return to IDLE.
- Latency: start sampled at edge E0; HI/LO update and done rises at edge E(WIDTH+1). busy is high from E0 to E(WIDTH+1). For WIDTH=32, done arrives 33 clocks after start.
- Arithmetic:
  - Full 2*WIDTH-bit product; hi holds bits [2W-1:W], lo holds bits [W-1:0].
  - Signed ops use two's-complement magnitudes.
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ; remainder takes the sign of the dividend.
  - DIV of MIN by -1 gives lo=MIN, hi=0 with no error flag.
- Division by zero (op 2/3 with opB==0): RUN is skipped and the state goes from IDLE straight to FIX. Result: lo=all ones, hi=opA unmodified, div_by_zero set. done rises at E1. div_by_zero is cleared only by reset or by the next start of a division with nonzero opB.
- start while busy: ignored, and no error is signalled.
- hi_we/lo_we: take effect at the next edge, only in IDLE with start=0.
  - If start and a write occur in the same cycle, start wins and the write is dropped.
  - Writes while busy are dropped.
  - hi_we and lo_we may both be asserted together.
- done is never asserted together with busy.
- HI/LO outputs hold their old values throughout RUN.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: in a multiply, RUN exits to FIX as soon as the remaining unshifted multiplier bits are all zero, with the partial product already aligned. Minimum multiply latency is done at E2 (opB==0 or 1). Division is unchanged.
- Not defined: fixed latency for all non-zero-divisor operations, with done at E(WIDTH+1).

Test Plan:
- MULTU, opA=0xFFFFFFFF, opB=2 -> hi=0x00000001, lo=0xFFFFFFFE. done pulses exactly 33 clocks after start (early-term off), busy high throughout.
- MULT, opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV, opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). A following DIVU 100/7 gives lo=14, hi=2.
- DIVU, opA=5, opB=0 -> done 1 clock after start, lo=0xFFFFFFFF, hi=5, div_by_zero=1. Flag stays 1 through a later MULTU and clears on DIVU 9/3.
- During a MULTU: a second start is ignored and lo_we with 0x1234 is dropped. Final result matches the first op. Then in IDLE, lo_we with 0x1234 gives lo=0x1234 next edge.
- rst_n pulsed low at RUN iteration 10 -> busy=0, hi=lo=0 immediately, and no done pulse afterwards. A new start after release completes normally.
